// File: rtl/game_tracker.sv
// Passive monitor for the adventure-game FSM: counts moves and invalid bounces,
// records visited state codes, and detects the ending route or move-budget timeout.
module game_tracker #(
    parameter int END_STATE     = 21,
    parameter int INVALID_STATE = 16,
    parameter int MOVE_W        = 6,
    parameter int MAX_MOVES     = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        state,
    output logic [MOVE_W-1:0] move_count,
    output logic [3:0]        invalid_count,
    output logic [31:0]       visited,
    output logic              step,
    output logic              done,
    output logic              timeout,
    output logic [1:0]        ending,
    output logic              bad_state
);

    typedef enum logic [1:0] {TRACK, DONE, TIMEOUT} fsm_t;

    localparam logic [MOVE_W-1:0] MOVE_SAT = '1;
    localparam logic [MOVE_W-1:0] MOVE_MAX = MOVE_W'(MAX_MOVES);
    localparam logic [4:0]        END_CODE = 5'(END_STATE);
    localparam logic [4:0]        INV_CODE = 5'(INVALID_STATE);

    fsm_t              fsm_reg;
    logic [4:0]        prev_state_reg;
    logic [MOVE_W-1:0] move_count_reg;
    logic [3:0]        invalid_count_reg;
    logic [31:0]       visited_reg;
    logic              step_reg;
    logic              done_reg;
    logic              timeout_reg;
    logic [1:0]        ending_reg;
    logic              bad_state_reg;

    logic              change;
    logic [MOVE_W-1:0] move_count_next;
    logic [1:0]        ending_next;
    logic [31:0]       state_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_hit
            assign state_hit[gi] = (state == 5'(gi));
        end
    endgenerate

    assign change = (state != prev_state_reg);

    always_comb begin
        move_count_next = move_count_reg;
        if (move_count_reg != MOVE_SAT)
            move_count_next = move_count_reg + 1'b1;
    end

    // Route into the ending is identified by the last room before END_STATE.
    always_comb begin
        ending_next = 2'd3;
        case (prev_state_reg)
            5'd9:    ending_next = 2'd0;
            5'd10:   ending_next = 2'd1;
            5'd13:   ending_next = 2'd2;
            default: ending_next = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_reg           <= TRACK;
            prev_state_reg    <= 5'd1;
            move_count_reg    <= '0;
            invalid_count_reg <= 4'd0;
            visited_reg       <= 32'h0000_0002;
            step_reg          <= 1'b0;
            done_reg          <= 1'b0;
            timeout_reg       <= 1'b0;
            ending_reg        <= 2'd0;
            bad_state_reg     <= 1'b0;
        end else begin
            step_reg <= 1'b0;
            if (fsm_reg == TRACK && change) begin
                prev_state_reg <= state;
                step_reg       <= 1'b1;
                move_count_reg <= move_count_next;
                visited_reg    <= visited_reg | state_hit;
                if (state == INV_CODE && invalid_count_reg != 4'd15)
                    invalid_count_reg <= invalid_count_reg + 4'd1;
                if (state > END_CODE)
                    bad_state_reg <= 1'b1;
                // Reaching the end on the final budgeted move counts as DONE.
                if (state == END_CODE) begin
                    fsm_reg    <= DONE;
                    done_reg   <= 1'b1;
                    ending_reg <= ending_next;
                end else if (move_count_next == MOVE_MAX) begin
                    fsm_reg     <= TIMEOUT;
                    timeout_reg <= 1'b1;
                end
            end
        end
    end

    assign move_count    = move_count_reg;
    assign invalid_count = invalid_count_reg;
    assign visited       = visited_reg;
    assign step          = step_reg;
    assign done          = done_reg;
    assign timeout       = timeout_reg;
    assign ending        = ending_reg;
    assign bad_state     = bad_state_reg;

endmodule

// File: tb/tb_game_tracker.sv
// Directed bench for game_tracker: a default instance plus a small-budget
// instance (MOVE_W=4, MAX_MOVES=8) share clock, reset and state stimulus.
module tb_game_tracker;

    logic        clk;
    logic        reset;
    logic [4:0]  state;

    logic [5:0]  move_count;
    logic [3:0]  invalid_count;
    logic [31:0] visited;
    logic        step, done, timeout, bad_state;
    logic [1:0]  ending;

    logic [3:0]  t_move_count;
    logic [3:0]  t_invalid_count;
    logic [31:0] t_visited;
    logic        t_step, t_done, t_timeout, t_bad_state;
    logic [1:0]  t_ending;

    int n_checks;
    int n_fail;

    game_tracker dut (
        .clk(clk), .reset(reset), .state(state),
        .move_count(move_count), .invalid_count(invalid_count), .visited(visited),
        .step(step), .done(done), .timeout(timeout), .ending(ending),
        .bad_state(bad_state)
    );

    game_tracker #(.MOVE_W(4), .MAX_MOVES(8)) dut_t (
        .clk(clk), .reset(reset), .state(state),
        .move_count(t_move_count), .invalid_count(t_invalid_count), .visited(t_visited),
        .step(t_step), .done(t_done), .timeout(t_timeout), .ending(t_ending),
        .bad_state(t_bad_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Present a state code, take one edge, and settle 1ns past it.
    task automatic drive(input logic [4:0] s);
        state = s;
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b state=%0d step=%0b moves=%0d inv=%0d vis=%h done=%0b to=%0b end=%0d bad=%0b | t_moves=%0d t_to=%0b",
                 $time, reset, s, step, move_count, invalid_count, visited, done, timeout,
                 ending, bad_state, t_move_count, t_timeout);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(5'd7);
        drive(5'd7);
        reset = 1'b1;
        drive(5'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        state    = 5'd7;
        #1;

        // Reset: two edges low with state=7
        reset = 1'b0;
        drive(5'd7);
        drive(5'd7);
        check("rst_moves",   32'(move_count), 32'd0);
        check("rst_inv",     32'(invalid_count), 32'd0);
        check("rst_visited", visited, 32'h0000_0002);
        check("rst_step",    32'(step), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_ending",  32'(ending), 32'd0);
        check("rst_bad",     32'(bad_state), 32'd0);
        reset = 1'b1;
        drive(5'd1);
        check("first_sample_no_step", 32'(step), 32'd0);
        check("first_sample_moves",   32'(move_count), 32'd0);

        // Ending path 1,2,6,10,21 -> unmotivated route
        drive(5'd1);  check("end_s1_step", 32'(step), 32'd0);
        drive(5'd2);  check("end_s2_step", 32'(step), 32'd1);
        drive(5'd6);  check("end_s6_step", 32'(step), 32'd1);
        drive(5'd10); check("end_s10_step", 32'(step), 32'd1);
                      check("end_s10_done", 32'(done), 32'd0);
        drive(5'd21); check("end_s21_step", 32'(step), 32'd1);
        check("end_moves",   32'(move_count), 32'd4);
        check("end_visited", visited, 32'h0020_0446);
        check("end_done",    32'(done), 32'd1);
        check("end_ending",  32'(ending), 32'd1);
        check("end_timeout", 32'(timeout), 32'd0);
        drive(5'd3);
        check("done_frozen_step",    32'(step), 32'd0);
        check("done_frozen_moves",   32'(move_count), 32'd4);
        check("done_frozen_visited", visited, 32'h0020_0446);
        check("done_frozen_ending",  32'(ending), 32'd1);

        // Invalid bounces: reset out of DONE
        do_reset();
        check("rst_from_done", 32'(done), 32'd0);
        drive(5'd16); check("inv_first", 32'(invalid_count), 32'd1);
        drive(5'd16); check("inv_stay_step", 32'(step), 32'd0);
                      check("inv_stay_count", 32'(invalid_count), 32'd1);
        drive(5'd1);
        drive(5'd16);
        drive(5'd1);
        check("inv_count",   32'(invalid_count), 32'd2);
        check("inv_moves",   32'(move_count), 32'd4);
        check("inv_visited", visited, 32'h0001_0002);
        check("inv_done",    32'(done), 32'd0);

        // Timeout on small-budget instance: 8 alternations
        do_reset();
        for (int i = 0; i < 7; i++) drive((i % 2 == 0) ? 5'd2 : 5'd1);
        check("to_before", 32'(t_timeout), 32'd0);
        check("to_moves7", 32'(t_move_count), 32'd7);
        drive(5'd1);
        check("to_hit",      32'(t_timeout), 32'd1);
        check("to_moves8",   32'(t_move_count), 32'd8);
        check("to_done",     32'(t_done), 32'd0);
        check("to_step",     32'(t_step), 32'd1);
        check("dflt_no_to",  32'(timeout), 32'd0);
        drive(5'd2);
        drive(5'd1);
        check("to_frozen_moves", 32'(t_move_count), 32'd8);
        check("to_frozen_step",  32'(t_step), 32'd0);
        check("dflt_moves10",    32'(move_count), 32'd10);

        // 7 alternations then 21 on the budget edge: DONE wins
        do_reset();
        check("rst_from_timeout", 32'(t_timeout), 32'd0);
        for (int i = 0; i < 7; i++) drive((i % 2 == 0) ? 5'd2 : 5'd1);
        drive(5'd21);
        check("tie_done",    32'(t_done), 32'd1);
        check("tie_timeout", 32'(t_timeout), 32'd0);
        check("tie_moves",   32'(t_move_count), 32'd8);
        check("tie_ending",  32'(t_ending), 32'd3);

        // Bad code
        do_reset();
        drive(5'd25);
        check("bad_flag",    32'(bad_state), 32'd1);
        check("bad_visited", visited, 32'h0200_0002);
        check("bad_moves",   32'(move_count), 32'd1);
        check("bad_done",    32'(done), 32'd0);
        drive(5'd21);
        check("bad_end_done",   32'(done), 32'd1);
        check("bad_end_ending", 32'(ending), 32'd3);

        // Reset mid-operation with a concurrent change
        do_reset();
        drive(5'd2);
        drive(5'd3);
        drive(5'd4);
        check("mid_moves3", 32'(move_count), 32'd3);
        reset = 1'b0;
        drive(5'd5);
        check("mid_rst_moves",   32'(move_count), 32'd0);
        check("mid_rst_step",    32'(step), 32'd0);
        check("mid_rst_visited", visited, 32'h0000_0002);
        reset = 1'b1;
        drive(5'd1);
        drive(5'd2);
        check("mid_after_moves", 32'(move_count), 32'd1);
        check("mid_after_step",  32'(step), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
